// File: rtl/square_game_ctrl.sv
// Frame-rate game sequencer: key-edge decode, IDLE/PLAY/PAUSE/OVER FSM, lives, respawn and score.
// All outputs registered (valid the frame after the causing input); no backpressure, one key edge acted on per frame.
module square_game_ctrl #(
  parameter int Y_MAX        = 479,
  parameter int LIVES_INIT   = 3,
  parameter int FLOOR_FRAMES = 4,
  parameter int GRACE_FRAMES = 30,
  parameter int SCORE_PERIOD = 60
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic [9:0]  S,
  output logic        move_en,
  output logic        respawn,
  output logic [1:0]  dir,
  output logic        dir_valid,
  output logic [1:0]  state,
  output logic [2:0]  lives,
  output logic [15:0] score
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;

  logic [7:0]  prev_key;
  logic [3:0]  floor_cnt, floor_cnt_nxt;
  logic [5:0]  grace_cnt, grace_cnt_nxt;
  logic [7:0]  frame_cnt, frame_cnt_nxt;
  logic [1:0]  state_nxt, dir_nxt;
  logic [2:0]  lives_nxt;
  logic [15:0] score_nxt;
  logic        move_en_nxt, respawn_nxt, dir_valid_nxt;

  logic        key_new, space_edge, dir_key, play_run, contact, life_loss, last_life;
  logic [1:0]  dir_code;
  logic [3:0]  floor_inc;
  logic        unused_x;

  assign unused_x   = ^X;
  assign key_new    = (keycode != prev_key) && (keycode != 8'h00);
  assign space_edge = key_new && (keycode == KEY_SPACE);
  assign contact    = ({1'b0, Y} + {1'b0, S}) >= 11'(Y_MAX);
  // A SPACE edge in PLAY pre-empts everything else that frame.
  assign play_run   = (state == ST_PLAY) && !space_edge;
  assign floor_inc  = floor_cnt + 4'd1;
  assign life_loss  = play_run && (grace_cnt == 6'd0) && contact &&
                      (floor_inc == 4'(FLOOR_FRAMES));
  assign last_life  = (lives == 3'd1);

  always_comb begin
    dir_key  = 1'b1;
    dir_code = 2'd0;
    case (keycode)
      KEY_W:   dir_code = 2'd0;
      KEY_A:   dir_code = 2'd1;
      KEY_S:   dir_code = 2'd2;
      KEY_D:   dir_code = 2'd3;
      default: dir_key  = 1'b0;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      prev_key  <= 8'h00;
      floor_cnt <= 4'd0;
      grace_cnt <= 6'd0;
      frame_cnt <= 8'd0;
      lives     <= 3'd0;
      score     <= 16'd0;
      dir       <= 2'd0;
      move_en   <= 1'b0;
      respawn   <= 1'b0;
      dir_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_key  <= keycode;
      floor_cnt <= floor_cnt_nxt;
      grace_cnt <= grace_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      lives     <= lives_nxt;
      score     <= score_nxt;
      dir       <= dir_nxt;
      move_en   <= move_en_nxt;
      respawn   <= respawn_nxt;
      dir_valid <= dir_valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (space_edge) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (space_edge)                  state_nxt = ST_PAUSE;
        else if (life_loss && last_life) state_nxt = ST_OVER;
      end
      ST_PAUSE: if (space_edge) state_nxt = ST_PLAY;
      default:  if (space_edge) state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    floor_cnt_nxt = floor_cnt;
    grace_cnt_nxt = grace_cnt;
    frame_cnt_nxt = frame_cnt;
    lives_nxt     = lives;
    score_nxt     = score;
    dir_nxt       = dir;
    respawn_nxt   = 1'b0;
    dir_valid_nxt = 1'b0;
    move_en_nxt   = (state_nxt == ST_PLAY);

    if ((state == ST_IDLE) && space_edge) begin
      lives_nxt     = 3'(LIVES_INIT);
      score_nxt     = 16'd0;
      frame_cnt_nxt = 8'd0;
      floor_cnt_nxt = 4'd0;
      grace_cnt_nxt = 6'(GRACE_FRAMES);
      respawn_nxt   = 1'b1;
    end

    if (play_run) begin
      if (grace_cnt != 6'd0) begin
        grace_cnt_nxt = grace_cnt - 6'd1;
        floor_cnt_nxt = 4'd0;
      end else if (contact) begin
        floor_cnt_nxt = life_loss ? 4'd0 : floor_inc;
      end else begin
        floor_cnt_nxt = 4'd0;
      end

      // Final life goes straight to OVER with no respawn.
      if (life_loss) begin
        lives_nxt = lives - 3'd1;
        if (!last_life) begin
          respawn_nxt   = 1'b1;
          grace_cnt_nxt = 6'(GRACE_FRAMES);
        end
      end

      if (frame_cnt == 8'(SCORE_PERIOD - 1)) begin
        frame_cnt_nxt = 8'd0;
        if (score != 16'hFFFF) score_nxt = score + 16'd1;
      end else begin
        frame_cnt_nxt = frame_cnt + 8'd1;
      end

      if (key_new && dir_key) begin
        dir_nxt       = dir_code;
        dir_valid_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_square_game_ctrl.sv
// Scenario bench for square_game_ctrl: each task queues expected outputs as it drives a frame, then pops and compares.
module tb_square_game_ctrl;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b0;
  logic [7:0]  keycode   = 8'h00;
  logic [9:0]  X = 10'd320;
  logic [9:0]  Y = 10'd100;
  logic [9:0]  S = 10'd16;
  logic        move_en, respawn, dir_valid;
  logic [1:0]  dir, state;
  logic [2:0]  lives;
  logic [15:0] score;

  typedef struct packed {
    logic [1:0]  state;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        move_en;
    logic        respawn;
    logic [1:0]  dir;
    logic        dir_valid;
  } obs_t;

  obs_t exp_q[$];
  obs_t e_o, g_o;
  int   checks   = 0;
  int   failures = 0;

  square_game_ctrl #(
    .Y_MAX(479), .LIVES_INIT(3), .FLOOR_FRAMES(4), .GRACE_FRAMES(30), .SCORE_PERIOD(60)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .X(X), .Y(Y), .S(S),
    .move_en(move_en), .respawn(respawn), .dir(dir), .dir_valid(dir_valid),
    .state(state), .lives(lives), .score(score)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic obs_t mk(input logic [1:0] st, input logic [2:0] lv, input logic [15:0] sc,
                              input logic mv, input logic rs, input logic [1:0] d, input logic dv);
    obs_t o;
    o.state = st; o.lives = lv; o.score = sc; o.move_en = mv;
    o.respawn = rs; o.dir = d; o.dir_valid = dv;
    return o;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.state = state; o.lives = lives; o.score = score; o.move_en = move_en;
    o.respawn = respawn; o.dir = dir; o.dir_valid = dir_valid;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("state=%0d lives=%0d score=%0d move_en=%0b respawn=%0b dir=%0d dir_valid=%0b",
                     o.state, o.lives, o.score, o.move_en, o.respawn, o.dir, o.dir_valid);
  endfunction

  task automatic frame();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset = 1'b0; keycode = 8'h00; Y = 10'd100; S = 10'd16;
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b1;
  endtask

  // Leaves the DUT one edge into PLAY: grace full, frame counter 0, SPACE released.
  task automatic start_game();
    do_reset();
    keycode = 8'h2C;
    frame();
    keycode = 8'h00;
  endtask

  task automatic test_reset();
    Reset = 1'b0; keycode = 8'h2C;
    exp_q.push_back(mk(IDLE, 3'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    @(negedge frame_clk);
    @(negedge frame_clk);
    e_o = exp_q.pop_front(); g_o = snap(); checks++;
    if (g_o !== e_o) begin failures++; $display("FAIL reset_hold: got %s, expected %s", fmt(g_o), fmt(e_o)); end
    keycode = 8'h00;
    @(negedge frame_clk);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(IDLE, 3'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      frame();
      e_o = exp_q.pop_front(); g_o = snap(); checks++;
      if (g_o !== e_o) begin failures++; $display("FAIL idle_quiet f%0d: got %s, expected %s", i, fmt(g_o), fmt(e_o)); end
    end
  endtask

  task automatic test_start();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      keycode = (i < 3) ? 8'h2C : 8'h00;
      exp_q.push_back(mk(PLAY, 3'd3, 16'd0, 1'b1, (i == 0), 2'd0, 1'b0));
      frame();
      e_o = exp_q.pop_front(); g_o = snap(); checks++;
      if (g_o !== e_o) begin failures++; $display("FAIL start f%0d: got %s, expected %s", i, fmt(g_o), fmt(e_o)); end
    end
  endtask

  task automatic test_floor_grace();
    start_game();
    for (int n = 1; n <= 72; n++) begin
      Y = (n == 68) ? 10'd100 : 10'd470;
      exp_q.push_back(mk(PLAY, 3'((n < 34) ? 3 : ((n < 72) ? 2 : 1)), 16'((n >= 60) ? 1 : 0),
                         1'b1, (n == 34 || n == 72), 2'd0, 1'b0));
      frame();
      e_o = exp_q.pop_front(); g_o = snap(); checks++;
      if (g_o !== e_o) begin failures++; $display("FAIL floor_grace f%0d: got %s, expected %s", n, fmt(g_o), fmt(e_o)); end
    end
  endtask

  task automatic test_game_over();
    start_game();
    Y = 10'd470;
    for (int n = 1; n <= 107; n++) begin
      exp_q.push_back(mk((n < 102) ? PLAY : OVER,
                         3'((n < 34) ? 3 : ((n < 68) ? 2 : ((n < 102) ? 1 : 0))),
                         16'((n >= 60) ? 1 : 0), (n < 102), (n == 34 || n == 68), 2'd0, 1'b0));
      frame();
      e_o = exp_q.pop_front(); g_o = snap(); checks++;
      if (g_o !== e_o) begin failures++; $display("FAIL game_over f%0d: got %s, expected %s", n, fmt(g_o), fmt(e_o)); end
    end
    Y = 10'd100;
    for (int j = 0; j < 3; j++) begin
      keycode = (j == 1) ? 8'h00 : 8'h2C;
      if (j < 2) exp_q.push_back(mk(IDLE, 3'd0, 16'd1, 1'b0, 1'b0, 2'd0, 1'b0));
      else       exp_q.push_back(mk(PLAY, 3'd3, 16'd0, 1'b1, 1'b1, 2'd0, 1'b0));
      frame();
      e_o = exp_q.pop_front(); g_o = snap(); checks++;
      if (g_o !== e_o) begin failures++; $display("FAIL over_restart s%0d: got %s, expected %s", j, fmt(g_o), fmt(e_o)); end
    end
    keycode = 8'h00;
  endtask

  task automatic test_score_pause();
    logic [1:0]  st;
    logic [15:0] sc;
    start_game();
    for (int n = 1; n <= 342; n++) begin
      keycode = (n == 181 || n == 282) ? 8'h2C : 8'h00;
      if (n <= 180)      begin st = PLAY;  sc = 16'(n / 60); end
      else if (n <= 281) begin st = PAUSE; sc = 16'd3; end
      else               begin st = PLAY;  sc = (n == 342) ? 16'd4 : 16'd3; end
      exp_q.push_back(mk(st, 3'd3, sc, (st == PLAY), 1'b0, 2'd0, 1'b0));
      frame();
      e_o = exp_q.pop_front(); g_o = snap(); checks++;
      if (g_o !== e_o) begin failures++; $display("FAIL score_pause f%0d: got %s, expected %s", n, fmt(g_o), fmt(e_o)); end
    end
    keycode = 8'h00;
  endtask

  task automatic test_dir();
    logic [7:0] ks [15] = '{8'h07, 8'h07, 8'h00, 8'h1A, 8'h00, 8'h04, 8'h16, 8'h00,
                            8'h2C, 8'h00, 8'h07, 8'h07, 8'h00, 8'h1A, 8'h00};
    logic [1:0] ds [15] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2,
                            2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    logic       dvs [15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    start_game();
    for (int i = 0; i < 15; i++) begin
      keycode = ks[i];
      exp_q.push_back(mk((i < 8) ? PLAY : PAUSE, 3'd3, 16'd0, (i < 8), 1'b0, ds[i], dvs[i]));
      frame();
      e_o = exp_q.pop_front(); g_o = snap(); checks++;
      if (g_o !== e_o) begin failures++; $display("FAIL dir step%0d key=%h: got %s, expected %s", i, ks[i], fmt(g_o), fmt(e_o)); end
    end
    keycode = 8'h00;
  endtask

  task automatic test_space_vs_loss();
    logic [1:0] st;
    start_game();
    Y = 10'd470;
    for (int n = 1; n <= 42; n++) begin
      keycode = (n == 34 || n == 40) ? 8'h2C : 8'h00;
      st = (n >= 34 && n < 40) ? PAUSE : PLAY;
      exp_q.push_back(mk(st, (n >= 41) ? 3'd2 : 3'd3, 16'd0, (st == PLAY), (n == 41), 2'd0, 1'b0));
      frame();
      e_o = exp_q.pop_front(); g_o = snap(); checks++;
      if (g_o !== e_o) begin failures++; $display("FAIL space_vs_loss f%0d: got %s, expected %s", n, fmt(g_o), fmt(e_o)); end
    end
    keycode = 8'h00;
  endtask

  task automatic test_async_reset();
    do_reset();
    keycode = 8'h2C;
    @(posedge frame_clk);
    #2;
    exp_q.push_back(mk(PLAY, 3'd3, 16'd0, 1'b1, 1'b1, 2'd0, 1'b0));
    e_o = exp_q.pop_front(); g_o = snap(); checks++;
    if (g_o !== e_o) begin failures++; $display("FAIL respawn_in_flight: got %s, expected %s", fmt(g_o), fmt(e_o)); end
    Reset = 1'b0;
    exp_q.push_back(mk(IDLE, 3'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    #1;
    e_o = exp_q.pop_front(); g_o = snap(); checks++;
    if (g_o !== e_o) begin failures++; $display("FAIL async_cancel: got %s, expected %s", fmt(g_o), fmt(e_o)); end
    @(negedge frame_clk);
    Reset = 1'b1;

    start_game();
    keycode = 8'h07;
    frame();
    keycode = 8'h00;
    exp_q.push_back(mk(PLAY, 3'd3, 16'd0, 1'b1, 1'b0, 2'd3, 1'b0));
    frame();
    e_o = exp_q.pop_front(); g_o = snap(); checks++;
    if (g_o !== e_o) begin failures++; $display("FAIL pre_reset_play: got %s, expected %s", fmt(g_o), fmt(e_o)); end
    @(posedge frame_clk);
    #2;
    Reset = 1'b0;
    exp_q.push_back(mk(IDLE, 3'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    #1;
    e_o = exp_q.pop_front(); g_o = snap(); checks++;
    if (g_o !== e_o) begin failures++; $display("FAIL async_mid_play: got %s, expected %s", fmt(g_o), fmt(e_o)); end
    @(negedge frame_clk);
    Reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_floor_grace();
    test_game_over();
    test_score_pause();
    test_dir();
    test_space_vs_loss();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/square_game_ctrl.md
Name: square_game_ctrl

Overview:
- Frame-rate game sequencer for the bouncing square mover.
- Decodes keycode edges and runs the game state machine (IDLE/PLAY/PAUSE/OVER).
- Gates square motion, issues respawn pulses and latched direction commands, tracks floor contact to count lives, and keeps a survival score.
- Sits between the USB keycode source and the square mover; all logic runs on frame_clk.

Parameters:
- Y_MAX, 479, bottom edge row used for floor-contact test.
- LIVES_INIT, 3, lives loaded on game start (1..7).
- FLOOR_FRAMES, 4, consecutive contact frames that cost one life (1..15).
- GRACE_FRAMES, 30, frames after respawn during which floor contact is ignored (0..63).
- SCORE_PERIOD, 60, PLAY frames per score increment (1..255).

Ports:
- frame_clk  in  1  frame clock; the only clock.
- Reset  in  1  asynchronous, active-low reset.
- keycode  in  8  current USB keycode; 0 = no key.
- X  in  10  square centre X (unused except as debug tap; must be connected).
- Y  in  10  square centre Y.
- S  in  10  square half-size.
- move_en  out  1  1 = square mover may update position this frame.
- respawn  out  1  one-frame pulse: mover reloads centre position and zero motion.
- dir  out  2  latched direction: 0=W, 1=A, 2=S, 3=D.
- dir_valid  out  1  one-frame pulse when dir is newly latched.
- state  out  2  0=IDLE, 1=PLAY, 2=PAUSE, 3=OVER.
- lives  out  3  remaining lives.
- score  out  16  survival score.

Behaviour:
- Reset (Reset=0, async) outputs and registers:
  - state=IDLE, lives=0, score=0, dir=0.
  - move_en=0, respawn=0, dir_valid=0.
  - prev_key=0; floor, grace and score counters = 0.
- Key edge:
  - key_new = (keycode != prev_key) && (keycode != 0).
  - prev_key <= keycode every frame.
  - A held key produces exactly one edge.
- SPACE = 8'h2C. Transitions are evaluated on key_new only:
  - IDLE + SPACE -> PLAY: lives<=LIVES_INIT, score<=0, respawn=1, grace<=GRACE_FRAMES.
  - PLAY + SPACE -> PAUSE.
  - PAUSE + SPACE -> PLAY; counters resume from held values, no respawn.
  - OVER + SPACE -> IDLE.
- move_en = (state==PLAY), registered, so it is valid in the same frame the state is valid.
- Direction keys (W=1A, A=04, S=16, D=07):
  - On key_new in PLAY only: dir <= code, dir_valid=1 for one frame.
  - Ignored in other states.
- Floor contact: contact = ((Y+S) >= Y_MAX), computed at 11 bits (no wrap).
- Floor counter, in PLAY:
  - If grace != 0: grace decrements, floor counter held at 0.
  - Else if contact: floor counter increments; otherwise it clears to 0.
- Life loss: when the floor counter reaches FLOOR_FRAMES:
  - Floor counter clears and lives decrements.
  - If new lives == 0: state -> OVER, move_en=0 next frame, no respawn.
  - Else: respawn=1 and grace <= GRACE_FRAMES.
- Score, in PLAY: the frame counter increments.
  - At SCORE_PERIOD-1 the frame counter wraps to 0 and score increments.
  - score saturates at 16'hFFFF.
  - Score is not cleared on OVER; it is cleared only on IDLE->PLAY.
- PAUSE, IDLE and OVER freeze all counters.
- Simultaneous events in PLAY, in priority order:
  1. SPACE edge (->PAUSE) wins: no life loss, counters hold that frame.
  2. Life loss.
  3. Score increment. Life loss and score increment in the same frame both apply.
- Reset mid-game: immediate return to reset values regardless of state; any respawn pulse in flight is cancelled.
- respawn and dir_valid are registered single-frame pulses and are never asserted outside PLAY entry or PLAY.

Test Plan:
- Reset released, keycode=2C for 3 frames then 0 -> single transition: state=1, lives=3, score=0, one respawn pulse, move_en=1 from the next frame; holding the key causes no PAUSE.
- PLAY, Y=470, S=16 held (contact), GRACE=30, FLOOR=4 -> lives stays 3 for 30 frames, drops to 2 at frame 34 with a respawn pulse; contact broken at count 3 restarts the count.
- Three successive floor losses -> lives 3->2->1->0; state=3 and move_en=0 on the third loss; no respawn on the last loss; score retained.
- PLAY for 180 frames -> score=3; SPACE -> PAUSE, 100 frames -> score still 3; SPACE -> score reaches 4 at 60 total PLAY frames after resume point count.
- PLAY, keycode sequence 07,07,00,1A -> dir=3 then dir=0, exactly two dir_valid pulses; the same sequence in PAUSE -> no pulses, dir unchanged.
- SPACE edge in the same frame floor counter hits FLOOR_FRAMES -> state=PAUSE, lives unchanged; Reset asserted mid-PLAY -> all outputs at reset values asynchronously.
